chnlnk_frame_fsm_param: RTL and testbench

- Parametrised channel-link frame sequencer. Per L1A event it reads SAMP_MAX+1 samples from the channel FIFO.
- Each sample frame is DATA_WORDS FIFO words followed by TAIL_WORDS generated tail words, with CRC-clear, valid, sequence and last-word strobes to the link serializer/CRC block.
- Adds three capabilities to the fixed 96+4-word sequencer: link backpressure, FIFO-underflow stall, and optional TMR with a mismatch flag.
- Sits between the L1A/sample FIFOs and the optical link framer.

---
 rtl/chnlnk_frame_fsm_param_if.sv | 31 +++
 rtl/chnlnk_frame_fsm_param.sv | 172 +++++++++++++++++
 tb/tb_chnlnk_frame_fsm_param.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chnlnk_frame_fsm_param_if.sv
// Link-side bundle of the frame sequencer: event/FIFO/link status in,
// serializer strobes and frame position out.
interface chnlnk_frame_fsm_param_if #(
    parameter int SEQ_W = 7,
    parameter int SMP_W = 7
) ();
    logic             L1A_BUF_MT;
    logic             F_MT;
    logic             LINK_RDY;
    logic [SMP_W-1:0] SAMP_MAX;
    logic             CLR_CRC;
    logic             RD;
    logic             VALID;
    logic             LAST_WRD;
    logic [SEQ_W-1:0] SEQ;
    logic [SMP_W-1:0] SMP;
    logic [2:0]       FRM_STATE;
    logic             TMR_ERR;

    // Environment side: drives status, observes strobes.
    modport master (
        output L1A_BUF_MT, F_MT, LINK_RDY, SAMP_MAX,
        input  CLR_CRC, RD, VALID, LAST_WRD, SEQ, SMP, FRM_STATE, TMR_ERR
    );

    // Sequencer side.
    modport slave (
        input  L1A_BUF_MT, F_MT, LINK_RDY, SAMP_MAX,
        output CLR_CRC, RD, VALID, LAST_WRD, SEQ, SMP, FRM_STATE, TMR_ERR
    );
endinterface

// File: rtl/chnlnk_frame_fsm_param.sv
// Channel-link frame sequencer: per L1A event emits SAMP_MAX+1 sample
// frames of DATA_WORDS FIFO words plus TAIL_WORDS tail words, with link
// backpressure, FIFO-underflow stall and optional triplicated registers.
module chnlnk_frame_fsm_param #(
    parameter int DATA_WORDS = 96,
    parameter int TAIL_WORDS = 4,
    parameter int SEQ_W      = 7,
    parameter int SMP_W      = 7,
    parameter int TMR        = 1
) (
    input  logic CLK,
    input  logic RST_N,
    chnlnk_frame_fsm_param_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_INC_SAMP    = 3'd1,
        S_LAST_WORD   = 3'd2,
        S_READ        = 3'd3,
        S_STRT_SAMPLE = 3'd4,
        S_TAIL        = 3'd5,
        S_TAIL_END    = 3'd6,
        S_W4DATA      = 3'd7
    } state_t;

    // Everything that is replicated under TMR; st sits in the low bits.
    typedef struct packed {
        logic [SMP_W-1:0] smax;
        logic [SMP_W-1:0] smp;
        logic [SEQ_W-1:0] seq;
        logic             last;
        logic             valid;
        logic             rd;
        logic             clr;
        state_t           st;
    } regs_t;

    localparam int NCOPY = (TMR != 0) ? 3 : 1;
    localparam int REG_W = $bits(regs_t);
    localparam logic [SEQ_W-1:0] SEQ_RD_LAST = SEQ_W'(DATA_WORDS - 1);
    localparam logic [SEQ_W-1:0] SEQ_TL_LAST = SEQ_W'(DATA_WORDS + TAIL_WORDS - 2);

    logic [NCOPY-1:0][REG_W-1:0] r_rep;
    logic                        r_tmr_err;
    logic [REG_W-1:0]            w_vote_v;
    logic                        w_mis;
    regs_t                       w_vote;
    regs_t                       w_next;
    logic                        w_go_rd;
    logic                        w_go_tl;

    generate
        if (TMR != 0) begin : g_tmr
            assign w_vote_v = (r_rep[0] & r_rep[1]) | (r_rep[0] & r_rep[2]) | (r_rep[1] & r_rep[2]);
            assign w_mis    = (r_rep[0] != w_vote_v) | (r_rep[1] != w_vote_v) | (r_rep[2] != w_vote_v);
        end else begin : g_single
            assign w_vote_v = r_rep[0];
            assign w_mis    = 1'b0;
        end
    endgenerate

    assign w_vote  = regs_t'(w_vote_v);
    assign w_go_rd = bus.LINK_RDY & ~bus.F_MT;
    assign w_go_tl = bus.LINK_RDY;

    // Next state/counters/strobes from the voted copy; strobes default low
    // so any stall cycle drops RD/VALID while state and counters hold.
    always_comb begin
        w_next       = w_vote;
        w_next.clr   = 1'b0;
        w_next.rd    = 1'b0;
        w_next.valid = 1'b0;
        w_next.last  = 1'b0;
        case (w_vote.st)
            S_IDLE: begin
                w_next.seq = '0;
                w_next.smp = '0;
                if (!bus.L1A_BUF_MT) begin
                    w_next.st   = S_W4DATA;
                    w_next.smax = bus.SAMP_MAX;
                    w_next.clr  = 1'b1;
                end
            end
            S_W4DATA: begin
                if (w_go_rd) begin
                    w_next.st    = S_STRT_SAMPLE;
                    w_next.seq   = '0;
                    w_next.rd    = 1'b1;
                    w_next.valid = 1'b1;
                end
            end
            S_STRT_SAMPLE: begin
                if (w_go_rd) begin
                    w_next.st    = S_READ;
                    w_next.seq   = w_vote.seq + 1'b1;
                    w_next.rd    = 1'b1;
                    w_next.valid = 1'b1;
                end
            end
            S_READ: begin
                if (w_vote.seq == SEQ_RD_LAST) begin
                    // Last FIFO word already issued; tail only needs the link.
                    if (w_go_tl) begin
                        w_next.st    = S_TAIL;
                        w_next.seq   = w_vote.seq + 1'b1;
                        w_next.valid = 1'b1;
                    end
                end else if (w_go_rd) begin
                    w_next.seq   = w_vote.seq + 1'b1;
                    w_next.rd    = 1'b1;
                    w_next.valid = 1'b1;
                end
            end
            S_TAIL: begin
                if (w_go_tl) begin
                    w_next.seq   = w_vote.seq + 1'b1;
                    w_next.valid = 1'b1;
                    if (w_vote.seq == SEQ_TL_LAST)
                        w_next.st = S_TAIL_END;
                end
            end
            S_TAIL_END: begin
                // Compare before incrementing so SMP never wraps at smax=max.
                w_next.seq = '0;
                if (w_vote.smp == w_vote.smax) begin
                    w_next.st   = S_LAST_WORD;
                    w_next.last = 1'b1;
                end else begin
                    w_next.st  = S_INC_SAMP;
                    w_next.smp = w_vote.smp + 1'b1;
                end
            end
            S_INC_SAMP: begin
                w_next.st  = S_W4DATA;
                w_next.seq = '0;
                w_next.clr = 1'b1;
            end
            S_LAST_WORD: begin
                w_next.st  = S_IDLE;
                w_next.seq = '0;
                w_next.smp = '0;
            end
            default: begin
                w_next.st  = S_IDLE;
                w_next.seq = '0;
                w_next.smp = '0;
            end
        endcase
    end

    // All replicas load the same voted next value, which scrubs an upset copy.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NCOPY; i++) r_rep[i] <= '0;
            r_tmr_err <= 1'b0;
        end else begin
            for (int i = 0; i < NCOPY; i++) r_rep[i] <= w_next;
            r_tmr_err <= w_mis;
        end
    end

    assign bus.CLR_CRC   = w_vote.clr;
    assign bus.RD        = w_vote.rd;
    assign bus.VALID     = w_vote.valid;
    assign bus.LAST_WRD  = w_vote.last;
    assign bus.SEQ       = w_vote.seq;
    assign bus.SMP       = w_vote.smp;
    assign bus.FRM_STATE = w_vote.st;
    assign bus.TMR_ERR   = r_tmr_err;

endmodule

// File: tb/tb_chnlnk_frame_fsm_param.sv
// Directed bench: default 96+4 TMR instance (a) and a small 8+2 single-copy
// instance (b), with stream monitors counting strobes and word order.
module tb_chnlnk_frame_fsm_param;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    chnlnk_frame_fsm_param_if #(.SEQ_W(7), .SMP_W(7)) a ();
    chnlnk_frame_fsm_param_if #(.SEQ_W(7), .SMP_W(2)) b ();

    chnlnk_frame_fsm_param #(.DATA_WORDS(96), .TAIL_WORDS(4), .SEQ_W(7), .SMP_W(7), .TMR(1))
        dut_a (.CLK(CLK), .RST_N(RST_N), .bus(a));
    chnlnk_frame_fsm_param #(.DATA_WORDS(8), .TAIL_WORDS(2), .SEQ_W(7), .SMP_W(2), .TMR(0))
        dut_b (.CLK(CLK), .RST_N(RST_N), .bus(b));

    int checks = 0;
    int failures = 0;

    // monitor state, instance a
    int a_clr = 0, a_rd = 0, a_val = 0, a_last = 0, a_terr = 0;
    int a_serr = 0, a_smperr = 0, a_rderr = 0, a_smp_last = -1;
    int a_exp_seq = 0, a_exp_smp = 0;
    bit a_prev_end = 0;
    // monitor state, instance b
    int b_clr = 0, b_rd = 0, b_val = 0, b_last = 0, b_terr = 0;
    int b_serr = 0, b_smperr = 0, b_rderr = 0, b_smp_last = -1;
    int b_exp_seq = 0, b_exp_smp = 0;
    bit b_prev_end = 0;

    // Stream monitor a: SEQ order 0..99, SMP order per sample, RD iff data word,
    // LAST_WRD only right after the SEQ=99 word.
    always @(negedge CLK) begin
        if (!RST_N) begin
            a_exp_seq = 0; a_exp_smp = 0; a_prev_end = 0;
        end else begin
            a_clr  += int'(a.CLR_CRC);
            a_rd   += int'(a.RD);
            a_val  += int'(a.VALID);
            a_last += int'(a.LAST_WRD);
            a_terr += int'(a.TMR_ERR);
            if (a.LAST_WRD) begin
                if (!a_prev_end) a_serr++;
                a_smp_last = int'(a.SMP);
                a_exp_smp = 0;
            end
            if (a.VALID) begin
                if (int'(a.SEQ) != a_exp_seq) a_serr++;
                if (a.SEQ == 7'd0) begin
                    if (int'(a.SMP) != a_exp_smp) a_smperr++;
                    a_exp_smp = int'(a.SMP) + 1;
                end
                if (a.RD != (a.SEQ < 7'd96)) a_rderr++;
                a_exp_seq = (a.SEQ == 7'd99) ? 0 : int'(a.SEQ) + 1;
            end else if (a.RD) a_rderr++;
            a_prev_end = a.VALID && (a.SEQ == 7'd99);
        end
    end

    // Stream monitor b: same rules for the 8+2 frame.
    always @(negedge CLK) begin
        if (!RST_N) begin
            b_exp_seq = 0; b_exp_smp = 0; b_prev_end = 0;
        end else begin
            b_clr  += int'(b.CLR_CRC);
            b_rd   += int'(b.RD);
            b_val  += int'(b.VALID);
            b_last += int'(b.LAST_WRD);
            b_terr += int'(b.TMR_ERR);
            if (b.LAST_WRD) begin
                if (!b_prev_end) b_serr++;
                b_smp_last = int'(b.SMP);
                b_exp_smp = 0;
            end
            if (b.VALID) begin
                if (int'(b.SEQ) != b_exp_seq) b_serr++;
                if (b.SEQ == 7'd0) begin
                    if (int'(b.SMP) != b_exp_smp) b_smperr++;
                    b_exp_smp = int'(b.SMP) + 1;
                end
                if (b.RD != (b.SEQ < 7'd8)) b_rderr++;
                b_exp_seq = (b.SEQ == 7'd9) ? 0 : int'(b.SEQ) + 1;
            end else if (b.RD) b_rderr++;
            b_prev_end = b.VALID && (b.SEQ == 7'd9);
        end
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag, input bit sel, input int budget);
        int n = 0;
        @(negedge CLK);
        while (((sel ? b.FRM_STATE : a.FRM_STATE) != 3'd0) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk(tag, longint'(n < budget), 1);
    endtask

    task automatic wait_word_a(input string tag, input int smp, input int seq, input int budget);
        int n = 0;
        while (!(a.VALID && int'(a.SEQ) == seq && int'(a.SMP) == smp) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk(tag, longint'(n < budget), 1);
    endtask

    // Pull L1A_BUF_MT low for exactly one edge on instance a.
    task automatic start_a(input logic [6:0] smax);
        a.SAMP_MAX = smax;
        a.L1A_BUF_MT = 1'b0;
        @(negedge CLK);
        a.L1A_BUF_MT = 1'b1;
    endtask

    int s_clr, s_rd, s_val, s_last, s_terr;

    task automatic snap_a();
        s_clr = a_clr; s_rd = a_rd; s_val = a_val; s_last = a_last; s_terr = a_terr;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        a.L1A_BUF_MT = 1'b1; a.F_MT = 1'b0; a.LINK_RDY = 1'b1; a.SAMP_MAX = '0;
        b.L1A_BUF_MT = 1'b1; b.F_MT = 1'b0; b.LINK_RDY = 1'b1; b.SAMP_MAX = '0;
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);

        // reset state
        chk("rst_outs_a", {a.CLR_CRC, a.RD, a.VALID, a.LAST_WRD, a.TMR_ERR, a.SEQ, a.SMP, a.FRM_STATE}, 0);
        chk("rst_outs_b", {b.CLR_CRC, b.RD, b.VALID, b.LAST_WRD, b.TMR_ERR, b.SEQ, b.SMP, b.FRM_STATE}, 0);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        chk("idle_hold", a.FRM_STATE, 0);

        // single sample, no stalls
        snap_a();
        start_a(7'd0);
        chk("t1_w4data", a.FRM_STATE, 7);
        chk("t1_clr", a.CLR_CRC, 1);
        @(negedge CLK);
        chk("t1_strt", {a.FRM_STATE, a.RD, a.VALID, a.SEQ}, {3'd4, 1'b1, 1'b1, 7'd0});
        @(negedge CLK);
        chk("t1_read", {a.FRM_STATE, a.RD, a.SEQ}, {3'd3, 1'b1, 7'd1});
        wait_idle("t1_done", 1'b0, 300);
        #2;
        chk("t1_clr_n", a_clr - s_clr, 1);
        chk("t1_rd_n", a_rd - s_rd, 96);
        chk("t1_val_n", a_val - s_val, 100);
        chk("t1_last_n", a_last - s_last, 1);
        chk("t1_terr_n", a_terr - s_terr, 0);

        // three samples; SAMP_MAX changed mid-event
        @(negedge CLK);
        snap_a();
        start_a(7'd2);
        repeat (3) @(negedge CLK);
        a.SAMP_MAX = 7'd0;
        wait_idle("t2_done", 1'b0, 1000);
        #2;
        chk("t2_clr_n", a_clr - s_clr, 3);
        chk("t2_rd_n", a_rd - s_rd, 288);
        chk("t2_val_n", a_val - s_val, 300);
        chk("t2_last_n", a_last - s_last, 1);
        chk("t2_smp_last", a_smp_last, 2);

        // FIFO underflow and link backpressure stalls
        @(negedge CLK);
        snap_a();
        start_a(7'd0);
        wait_word_a("t3_seq10", 0, 10, 200);
        a.F_MT = 1'b1;
        @(negedge CLK);
        chk("t3_fstall1", {a.RD, a.VALID, a.SEQ}, {1'b0, 1'b0, 7'd10});
        repeat (2) @(negedge CLK);
        chk("t3_fstall3", {a.FRM_STATE, a.RD, a.VALID, a.SEQ}, {3'd3, 1'b0, 1'b0, 7'd10});
        a.F_MT = 1'b0;
        @(negedge CLK);
        chk("t3_fresume", {a.RD, a.VALID, a.SEQ}, {1'b1, 1'b1, 7'd11});
        wait_word_a("t3_seq40", 0, 40, 200);
        a.LINK_RDY = 1'b0;
        repeat (5) @(negedge CLK);
        chk("t3_lstall5", {a.FRM_STATE, a.RD, a.VALID, a.SEQ}, {3'd3, 1'b0, 1'b0, 7'd40});
        a.LINK_RDY = 1'b1;
        @(negedge CLK);
        chk("t3_lresume", {a.RD, a.VALID, a.SEQ}, {1'b1, 1'b1, 7'd41});
        wait_word_a("t3_seq96", 0, 96, 200);
        a.F_MT = 1'b1;   // empty FIFO must not stall the tail
        @(negedge CLK);
        chk("t3_tail_fmt", {a.FRM_STATE, a.RD, a.VALID, a.SEQ}, {3'd5, 1'b0, 1'b1, 7'd97});
        a.F_MT = 1'b0;
        a.LINK_RDY = 1'b0;
        @(negedge CLK);
        chk("t3_tail_stall", {a.VALID, a.SEQ}, {1'b0, 7'd97});
        a.LINK_RDY = 1'b1;
        @(negedge CLK);
        chk("t3_tail_resume", {a.VALID, a.SEQ}, {1'b1, 7'd98});
        wait_idle("t3_done", 1'b0, 300);
        #2;
        chk("t3_rd_n", a_rd - s_rd, 96);
        chk("t3_val_n", a_val - s_val, 100);
        chk("t3_last_n", a_last - s_last, 1);

        // small instance, smax at full SMP_W range
        @(negedge CLK);
        b.SAMP_MAX = 2'd3;
        b.L1A_BUF_MT = 1'b0;
        @(negedge CLK);
        b.L1A_BUF_MT = 1'b1;
        chk("t4_w4data", {b.FRM_STATE, b.CLR_CRC}, {3'd7, 1'b1});
        wait_idle("t4_done", 1'b1, 200);
        #2;
        chk("t4_clr_n", b_clr, 4);
        chk("t4_rd_n", b_rd, 32);
        chk("t4_val_n", b_val, 40);
        chk("t4_last_n", b_last, 1);
        chk("t4_smp_last", b_smp_last, 3);
        chk("t4_terr_n", b_terr, 0);

        // asynchronous reset mid-frame, then fresh event
        @(negedge CLK);
        snap_a();
        start_a(7'd2);
        wait_word_a("t5_s1_seq50", 1, 50, 400);
        RST_N = 1'b0;
        #1;
        chk("t5_async_rst", {a.CLR_CRC, a.RD, a.VALID, a.LAST_WRD, a.TMR_ERR, a.SEQ, a.SMP, a.FRM_STATE}, 0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        #2;
        chk("t5_no_last", a_last - s_last, 0);
        snap_a();
        start_a(7'd0);
        chk("t5_restart", {a.FRM_STATE, a.CLR_CRC, a.SMP}, {3'd7, 1'b1, 7'd0});
        wait_idle("t5_done", 1'b0, 300);
        #2;
        chk("t5_rd_n", a_rd - s_rd, 96);
        chk("t5_last_n", a_last - s_last, 1);

        // upset one replica of the state register mid-Read
        @(negedge CLK);
        snap_a();
        start_a(7'd0);
        wait_word_a("t6_seq30", 0, 30, 200);
        dut_a.r_rep[2][2] = ~dut_a.r_rep[2][2];
        #1;
        chk("t6_vote_hold", {a.FRM_STATE, a.SEQ, a.TMR_ERR}, {3'd3, 7'd30, 1'b0});
        @(negedge CLK);
        chk("t6_err_pulse", {a.TMR_ERR, a.FRM_STATE, a.VALID, a.SEQ}, {1'b1, 3'd3, 1'b1, 7'd31});
        @(negedge CLK);
        chk("t6_err_clear", {a.TMR_ERR, a.SEQ}, {1'b0, 7'd32});
        wait_idle("t6_done", 1'b0, 300);
        #2;
        chk("t6_rd_n", a_rd - s_rd, 96);
        chk("t6_terr_n", a_terr - s_terr, 1);

        // stream-order bookkeeping over the whole run
        chk("seq_order_a", a_serr, 0);
        chk("smp_order_a", a_smperr, 0);
        chk("rd_valid_a", a_rderr, 0);
        chk("seq_order_b", b_serr, 0);
        chk("smp_order_b", b_smperr, 0);
        chk("rd_valid_b", b_rderr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
